mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_if.sv | 29 ++
 rtl/mult_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier signal bundle for mult_arbiter.
// The arbiter connects through slave; the environment drives through master.
interface mult_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [16*N_REQ-1:0] req_a;
    logic [16*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    resp_valid;
    logic [15:0]         resp_data;
    logic                resp_err;
    logic                busy;
    logic [2:0]          grant_id;
    logic                m_start;
    logic [15:0]         m_a;
    logic [15:0]         m_b;
    logic                m_done;
    logic [15:0]         m_result;

    modport slave (
        input  req, req_a, req_b, m_done, m_result,
        output resp_valid, resp_data, resp_err, busy, grant_id, m_start, m_a, m_b
    );

    modport master (
        output req, req_a, req_b, m_done, m_result,
        input  resp_valid, resp_data, resp_err, busy, grant_id, m_start, m_a, m_b
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier among N_REQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a WAIT-state watchdog that aborts with resp_err.
module mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | arbitrate pending requests
    // ISSUE | one-cycle m_start to the multiplier
    // WAIT  | wait for a rising edge on m_done
    // RESP  | one-cycle resp_valid to the granted requester
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] N_REQ4 = 4'(N_REQ);
    localparam logic [2:0] LAST_ID = 3'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       grant_id_q, grant_id_d;
    logic [15:0]      m_a_q, m_a_d;
    logic [15:0]      m_b_q, m_b_d;
    logic [15:0]      resp_data_q, resp_data_d;
    logic             done_prev_q;
    logic             done_edge;
    logic [N_REQ-1:0] req_rot;
    logic             found;
    logic [2:0]       offset;
    logic [3:0]       pick_sum;
    logic [2:0]       pick;
    logic [15:0]      pick_a, pick_b;
`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_err_q, resp_err_d;
`endif

    assign done_edge = bus.m_done & ~done_prev_q;
    // Rotate so that bit 0 is the requester at ptr; lowest set bit wins.
    assign req_rot = (bus.req >> ptr_q) | (bus.req << (N_REQ4 - {1'b0, ptr_q}));

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found  = 1'b1;
                offset = 3'(i);
            end
        end
        pick_sum = {1'b0, ptr_q} + {1'b0, offset};
        if (pick_sum >= N_REQ4) pick_sum = pick_sum - N_REQ4;
        pick   = 3'(pick_sum);
        pick_a = '0;
        pick_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == 3'(i)) begin
                pick_a = bus.req_a[16*i +: 16];
                pick_b = bus.req_b[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        m_a_d       = m_a_q;
        m_b_d       = m_b_q;
        resp_data_d = resp_data_q;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        resp_err_d  = resp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = ISSUE;
                    grant_id_d = pick;
                    ptr_d      = (pick == LAST_ID) ? 3'd0 : pick + 3'd1;
                    m_a_d      = pick_a;
                    m_b_d      = pick_b;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (done_edge) begin
                    state_d     = RESP;
                    resp_data_d = bus.m_result;
`ifdef MULT_ARB_TIMEOUT_EN
                    resp_err_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    resp_data_d = 16'h0000;
                    resp_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            m_a_q       <= '0;
            m_b_q       <= '0;
            resp_data_q <= '0;
            done_prev_q <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            resp_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            m_a_q       <= m_a_d;
            m_b_q       <= m_b_d;
            resp_data_q <= resp_data_d;
            done_prev_q <= bus.m_done;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            resp_err_q  <= resp_err_d;
`endif
        end
    end

    always_comb begin
        bus.resp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.resp_valid[i] = (state_q == RESP) && (grant_id_q == 3'(i));
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.m_start   = (state_q == ISSUE);
    assign bus.grant_id  = grant_id_q;
    assign bus.m_a       = m_a_q;
    assign bus.m_b       = m_b_q;
    assign bus.resp_data = resp_data_q;
`ifdef MULT_ARB_TIMEOUT_EN
    assign bus.resp_err  = resp_err_q;
`else
    assign bus.resp_err  = 1'b0;
`endif
endmodule
